// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and requester ids for the register-file writeback arbiter.
package regfile_wb_arbiter_pkg;

  localparam int ADDR_W      = 5;
  localparam int DATA_W      = 32;
  localparam int NUM_REQ_DEF = 3;
  localparam int GID_W       = 3;

  localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef enum logic [GID_W-1:0] {
    REQ_ALU    = 3'd0,
    REQ_LOAD   = 3'd1,
    REQ_MULDIV = 3'd2
  } req_id_e;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bus plus the registered write-port outputs toward reg_file.
interface regfile_wb_arbiter_if
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      reg_write;
  logic [ADDR_W-1:0]         write_addr;
  logic [DATA_W-1:0]         write_data;
  logic [GID_W-1:0]          grant_id;
  logic                      busy;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, reg_write, write_addr, write_data, grant_id, busy
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, reg_write, write_addr, write_data, grant_id, busy
  );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N     = 3,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [PTR_W-1:0] gnt_idx,
  output logic             gnt_any
);

  int idx;

  // NOTE: every comb output gets a default before the scan so no latch is inferred.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int off = 0; off < N; off++) begin
      idx = (int'(ptr) + off) % N;
      if (!gnt_any && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = PTR_W'(idx);
        gnt_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the single reg_file write port among NUM_REQ writeback sources.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF
) (
  input logic                  clk,
  input logic                  reset,
  regfile_wb_arbiter_if.slave  bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] zero_hit;
  logic [NUM_REQ-1:0] gnt;
  logic [PTR_W-1:0]   gnt_idx;
  logic               gnt_any;
  logic [PTR_W-1:0]   ptr;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;

  logic               reg_write_q;
  logic [ADDR_W-1:0]  write_addr_q;
  logic [DATA_W-1:0]  write_data_q;
  logic [GID_W-1:0]   grant_id_q;

  // Writes to r0 are acknowledged immediately and never compete for the port.
  always_comb begin
    eligible = '0;
    zero_hit = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = bus.req_valid[i] && (bus.req_addr[i*ADDR_W +: ADDR_W] != ZERO_REG);
      zero_hit[i] = bus.req_valid[i] && (bus.req_addr[i*ADDR_W +: ADDR_W] == ZERO_REG);
    end
  end

  rr_arbiter #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_rr (
    .req     (eligible),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
        sel_data = bus.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous, sampled at posedge.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr          <= '0;
      reg_write_q  <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
      grant_id_q   <= '0;
    end else begin
      reg_write_q <= gnt_any;
      if (gnt_any) begin
        ptr          <= (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        write_addr_q <= sel_addr;
        write_data_q <= sel_data;
        grant_id_q   <= GID_W'(gnt_idx);
      end
    end
  end

  // Ready is independent of the output stage, which drains every cycle.
  assign bus.req_ready  = reset ? '0 : (gnt | zero_hit);
  assign bus.reg_write  = reg_write_q;
  assign bus.write_addr = write_addr_q;
  assign bus.write_data = write_data_q;
  assign bus.grant_id   = grant_id_q;
  assign bus.busy       = (|bus.req_valid) | reg_write_q;

endmodule
